// File: rtl/special_walls_streamer.sv
// special_walls_streamer: walks a combinational sprite ROM once per start pulse and
// streams each palette index as a pixel beat with screen coordinates over valid/ready.
// Transparent pixels may be dropped (SKIP_TRANSP); dropped pixels still advance the walk.
//
// Ports:
//   Clk, Reset_n          clock (rising edge), asynchronous active-low reset
//   start                 1-cycle walk request, honoured only in IDLE
//   base_x, base_y        sprite origin, captured on an accepted start
//   rom_addr / rom_data   ROM address out, read data in (same cycle)
//   pix_valid/pix_ready   output stream handshake
//   pix_x, pix_y          base + column/row, wrapping at COORD_W bits
//   pix_color, pix_last   palette index, beat carries address DEPTH-1
//   busy, done            walk in progress, 1-cycle completion pulse
module special_walls_streamer #(
    parameter int unsigned       DEPTH       = 167,
    parameter int unsigned       ADDR_W      = 8,
    parameter int unsigned       DATA_W      = 4,
    parameter int unsigned       ROW_LEN     = 167,
    parameter int unsigned       COORD_W     = 10,
    parameter logic [DATA_W-1:0] TRANSPARENT = 4'hF,
    parameter bit                SKIP_TRANSP = 1'b1
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               start,
    input  logic [COORD_W-1:0] base_x,
    input  logic [COORD_W-1:0] base_y,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [DATA_W-1:0]  rom_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [DATA_W-1:0]  pix_color,
    output logic               pix_last,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t             state_q, state_d;
    logic [COORD_W-1:0] col_q, col_d, row_q, row_d;
    logic [COORD_W-1:0] bx_q, bx_d, by_q, by_d;
    logic [ADDR_W-1:0]  addr_d;
    logic               valid_d, last_d, busy_d, done_d;
    logic [COORD_W-1:0] x_d, y_d;
    logic [DATA_W-1:0]  color_d;

    logic slot_free_c, addr_last_c, col_last_c;

    // Output register can take a new beat when empty or being drained this cycle
    assign slot_free_c = !pix_valid || pix_ready;
    assign addr_last_c = (rom_addr == ADDR_W'(DEPTH - 1));
    assign col_last_c  = (col_q == COORD_W'(ROW_LEN - 1));

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        bx_d    = bx_q;
        by_d    = by_q;
        addr_d  = rom_addr;
        valid_d = pix_valid;
        x_d     = pix_x;
        y_d     = pix_y;
        color_d = pix_color;
        last_d  = pix_last;
        busy_d  = busy;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    addr_d  = '0;
                    col_d   = '0;
                    row_d   = '0;
                    bx_d    = base_x;
                    by_d    = base_y;
                end
            end
            RUN: begin
                if (slot_free_c) begin
                    color_d = rom_data;
                    x_d     = bx_q + col_q;
                    y_d     = by_q + row_q;
                    last_d  = addr_last_c;
                    valid_d = !(SKIP_TRANSP && (rom_data == TRANSPARENT));
                    if (col_last_c) begin
                        col_d = '0;
                        row_d = row_q + COORD_W'(1);
                    end else begin
                        col_d = col_q + COORD_W'(1);
                    end
                    if (addr_last_c) begin
                        addr_d  = '0;
                        state_d = FLUSH;
                    end else begin
                        addr_d = rom_addr + ADDR_W'(1);
                    end
                end
            end
            FLUSH: begin
                // Last beat leaves (or was never valid): finish the walk
                if (slot_free_c) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            bx_q      <= '0;
            by_q      <= '0;
            rom_addr  <= '0;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_color <= '0;
            pix_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            bx_q      <= bx_d;
            by_q      <= by_d;
            rom_addr  <= addr_d;
            pix_valid <= valid_d;
            pix_x     <= x_d;
            pix_y     <= y_d;
            pix_color <= color_d;
            pix_last  <= last_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_special_walls_streamer.sv
// Bench for special_walls_streamer: instance 0 uses defaults (skip transparent, 167-wide
// rows), instance 1 emits every pixel with 16-wide rows. Each instance reads its own ROM
// array; expected beats come from a direct address -> (column,row) model.
module tb_special_walls_streamer;

    localparam int DEPTH = 167;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] c;
        logic       l;
    } beat_t;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       start     [2];
    logic [9:0] base_x    [2];
    logic [9:0] base_y    [2];
    logic [7:0] rom_addr  [2];
    logic [3:0] rom_data_a, rom_data_b;
    logic       pix_valid [2];
    logic       pix_ready [2];
    logic [9:0] pix_x     [2];
    logic [9:0] pix_y     [2];
    logic [3:0] pix_color [2];
    logic       pix_last  [2];
    logic       busy      [2];
    logic       done      [2];

    logic [3:0] rom [2][256];
    beat_t      got[$];
    int         total = 0;
    int         bad   = 0;

    always #5 Clk = ~Clk;

    assign rom_data_a = rom[0][rom_addr[0]];
    assign rom_data_b = rom[1][rom_addr[1]];

    special_walls_streamer u_a (
        .Clk(Clk), .Reset_n(Reset_n), .start(start[0]),
        .base_x(base_x[0]), .base_y(base_y[0]),
        .rom_addr(rom_addr[0]), .rom_data(rom_data_a),
        .pix_valid(pix_valid[0]), .pix_ready(pix_ready[0]),
        .pix_x(pix_x[0]), .pix_y(pix_y[0]), .pix_color(pix_color[0]),
        .pix_last(pix_last[0]), .busy(busy[0]), .done(done[0])
    );

    special_walls_streamer #(.ROW_LEN(16), .SKIP_TRANSP(1'b0)) u_b (
        .Clk(Clk), .Reset_n(Reset_n), .start(start[1]),
        .base_x(base_x[1]), .base_y(base_y[1]),
        .rom_addr(rom_addr[1]), .rom_data(rom_data_b),
        .pix_valid(pix_valid[1]), .pix_ready(pix_ready[1]),
        .pix_x(pix_x[1]), .pix_y(pix_y[1]), .pix_color(pix_color[1]),
        .pix_last(pix_last[1]), .busy(busy[1]), .done(done[1])
    );

    task automatic fill_rom(input int which, input int lo, input int hi);
        for (int i = 0; i < 256; i++) rom[which][i] = 4'($urandom_range(hi, lo));
    endtask

    // Drives one walk and checks every accepted beat, stall holds, busy and done timing
    task automatic run_walk(input int which, input logic [9:0] bx, input logic [9:0] by,
                            input bit rand_ready, input bit mid_start, input int reset_at,
                            input int exp_done);
        beat_t exp_q[$];
        beat_t e;
        beat_t held;
        bit    skip    = (which == 0);
        int    row_len = (which == 0) ? 167 : 16;
        int    cyc;
        int    busy_errs = 0;
        int    done_cycle = -1;
        bit    stalled = 1'b0;
        bit    ready;

        for (int a = 0; a < DEPTH; a++) begin
            if (skip && rom[which][a] == 4'hF) continue;
            e.x = 10'(int'(bx) + (a % row_len));
            e.y = 10'(int'(by) + (a / row_len));
            e.c = rom[which][a];
            e.l = (a == DEPTH - 1);
            exp_q.push_back(e);
        end
        got.delete();

        @(negedge Clk);
        base_x[which]    = bx;
        base_y[which]    = by;
        start[which]     = 1'b1;
        pix_ready[which] = 1'b1;
        @(negedge Clk);
        start[which] = 1'b0;
        cyc = 1;

        while (cyc < 3000) begin
            if (stalled) begin
                total++;
                if (pix_valid[which] !== 1'b1 || pix_x[which] !== held.x || pix_y[which] !== held.y ||
                    pix_color[which] !== held.c || pix_last[which] !== held.l) begin
                    bad++;
                    $display("FAIL stall_hold inst%0d cyc%0d: got v=%0b x=%0d y=%0d c=%0h l=%0b, held x=%0d y=%0d c=%0h l=%0b",
                             which, cyc, pix_valid[which], pix_x[which], pix_y[which], pix_color[which],
                             pix_last[which], held.x, held.y, held.c, held.l);
                end
            end
            if (done[which] === 1'b1) begin
                done_cycle = cyc;
                break;
            end
            if (busy[which] !== 1'b1) busy_errs++;

            start[which] = 1'b0;
            if (mid_start && cyc == 60) begin
                start[which]  = 1'b1;
                base_x[which] = bx + 10'd100;
            end

            ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
            pix_ready[which] = ready;

            if (pix_valid[which] === 1'b1 && ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_beat inst%0d: got x=%0d y=%0d c=%0h, expected none",
                             which, pix_x[which], pix_y[which], pix_color[which]);
                end else begin
                    e = exp_q.pop_front();
                    if (pix_x[which] !== e.x || pix_y[which] !== e.y ||
                        pix_color[which] !== e.c || pix_last[which] !== e.l) begin
                        bad++;
                        $display("FAIL beat%0d inst%0d: got x=%0d y=%0d c=%0h l=%0b, expected x=%0d y=%0d c=%0h l=%0b",
                                 got.size(), which, pix_x[which], pix_y[which], pix_color[which],
                                 pix_last[which], e.x, e.y, e.c, e.l);
                    end
                end
                got.push_back({pix_x[which], pix_y[which], pix_color[which], pix_last[which]});
                if (reset_at >= 0 && got.size() == reset_at) begin
                    Reset_n = 1'b0;
                    #1;
                    total++;
                    if ({rom_addr[which], pix_valid[which], pix_x[which], pix_y[which], pix_color[which],
                         pix_last[which], busy[which], done[which]} !== '0) begin
                        bad++;
                        $display("FAIL async_reset inst%0d: got addr=%0d v=%0b x=%0d y=%0d c=%0h l=%0b busy=%0b done=%0b, expected all 0",
                                 which, rom_addr[which], pix_valid[which], pix_x[which], pix_y[which],
                                 pix_color[which], pix_last[which], busy[which], done[which]);
                    end
                    @(negedge Clk);
                    Reset_n = 1'b1;
                    start[which] = 1'b0;
                    return;
                end
            end
            stalled = (pix_valid[which] === 1'b1) && !ready;
            held    = {pix_x[which], pix_y[which], pix_color[which], pix_last[which]};
            @(negedge Clk);
            cyc++;
        end

        total++;
        if (done_cycle < 0) begin
            bad++;
            $display("FAIL done_timeout inst%0d: no done within %0d cycles, expected done", which, cyc);
        end
        total++;
        if (busy_errs != 0) begin
            bad++;
            $display("FAIL busy_window inst%0d: busy low in %0d cycles, expected 0", which, busy_errs);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL beat_count inst%0d: got %0d beats, expected %0d", which, got.size(),
                     got.size() + exp_q.size());
        end
        if (done_cycle >= 0) begin
            total++;
            if (busy[which] !== 1'b0) begin
                bad++;
                $display("FAIL busy_at_done inst%0d: got %0b, expected 0", which, busy[which]);
            end
        end
        if (exp_done >= 0) begin
            total++;
            if (done_cycle != exp_done) begin
                bad++;
                $display("FAIL done_cycle inst%0d: got %0d, expected %0d", which, done_cycle, exp_done);
            end
        end
        // start during the DONE cycle must not launch a walk
        start[which] = mid_start;
        @(negedge Clk);
        start[which] = 1'b0;
        total++;
        if (done[which] !== 1'b0 || busy[which] !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse inst%0d: got done=%0b busy=%0b, expected 0 0", which, done[which], busy[which]);
        end
        @(negedge Clk);
        total++;
        if (busy[which] !== 1'b0) begin
            bad++;
            $display("FAIL start_in_done inst%0d: got busy=%0b, expected 0", which, busy[which]);
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; base_x[i] = '0; base_y[i] = '0; pix_ready[i] = 1'b1;
        end
        repeat (3) @(negedge Clk);
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({rom_addr[i], pix_valid[i], pix_x[i], pix_y[i], pix_color[i], pix_last[i], busy[i], done[i]} !== '0) begin
                bad++;
                $display("FAIL reset_state inst%0d: got addr=%0d v=%0b x=%0d y=%0d busy=%0b done=%0b, expected all 0",
                         i, rom_addr[i], pix_valid[i], pix_x[i], pix_y[i], busy[i], done[i]);
            end
        end
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_transparent_skip();
        fill_rom(0, 15, 15);
        run_walk(0, 10'd10, 10'd20, 1'b0, 1'b0, -1, 169);
    endtask

    task automatic test_all_emit();
        fill_rom(1, 15, 15);
        run_walk(1, 10'd10, 10'd20, 1'b0, 1'b0, -1, 169);
    endtask

    task automatic test_first_last();
        fill_rom(0, 0, 15);
        rom[0][0]   = 4'h3;
        rom[0][166] = 4'h5;
        run_walk(0, 10'd10, 10'd20, 1'b0, 1'b0, -1, 169);
        total++;
        if (got.size() == 0 || got[0] !== {10'd10, 10'd20, 4'h3, 1'b0}) begin
            bad++;
            $display("FAIL first_beat: got %0d beats / %h, expected x=10 y=20 c=3 l=0",
                     got.size(), (got.size() > 0) ? got[0] : '0);
        end
        total++;
        if (got.size() == 0 || got[got.size()-1] !== {10'd176, 10'd20, 4'h5, 1'b1}) begin
            bad++;
            $display("FAIL last_beat: got %h, expected x=176 y=20 c=5 l=1",
                     (got.size() > 0) ? got[got.size()-1] : '0);
        end
    endtask

    task automatic test_row_wrap();
        fill_rom(1, 0, 15);
        run_walk(1, 10'd0, 10'd0, 1'b0, 1'b0, -1, 169);
        total++;
        if (got.size() != DEPTH || got[16].x !== 10'd0 || got[16].y !== 10'd1 ||
            got[166].x !== 10'd6 || got[166].y !== 10'd10) begin
            bad++;
            $display("FAIL row_wrap: got %0d beats, b16=(%0d,%0d) b166=(%0d,%0d), expected 167 (0,1) (6,10)",
                     got.size(), (got.size() > 16) ? got[16].x : 10'd0, (got.size() > 16) ? got[16].y : 10'd0,
                     (got.size() > 166) ? got[166].x : 10'd0, (got.size() > 166) ? got[166].y : 10'd0);
        end
    endtask

    task automatic test_stall();
        fill_rom(0, 0, 15);
        run_walk(0, 10'd300, 10'd400, 1'b1, 1'b0, -1, -1);
        fill_rom(1, 0, 15);
        run_walk(1, 10'd5, 10'd1015, 1'b1, 1'b0, -1, -1);
    endtask

    task automatic test_x_wrap();
        fill_rom(1, 0, 15);
        run_walk(1, 10'd1020, 10'd7, 1'b0, 1'b0, -1, 169);
        total++;
        if (got.size() < 5 || got[4].x !== 10'd0) begin
            bad++;
            $display("FAIL x_wrap: got beat4 x=%0d (%0d beats), expected 0",
                     (got.size() > 4) ? got[4].x : 10'd0, got.size());
        end
    endtask

    task automatic test_mid_start();
        fill_rom(1, 0, 15);
        run_walk(1, 10'd40, 10'd50, 1'b1, 1'b1, -1, -1);
        fill_rom(0, 0, 15);
        run_walk(0, 10'd12, 10'd34, 1'b0, 1'b1, -1, 169);
    endtask

    task automatic test_reset_mid_walk();
        fill_rom(0, 0, 14);
        run_walk(0, 10'd77, 10'd88, 1'b0, 1'b0, 50, -1);
        run_walk(0, 10'd77, 10'd88, 1'b0, 1'b0, -1, 169);
    endtask

    initial begin
        test_reset();
        test_transparent_skip();
        test_all_emit();
        test_first_last();
        test_row_wrap();
        test_stall();
        test_x_wrap();
        test_mid_start();
        test_reset_mid_walk();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
